// File: rtl/stack_sequencer.sv
// Multi-cycle PUSH/POP controller: R3 of the register file is the stack pointer,
// and the sequencer drives the shared register-file and data-memory ports while busy.
module stack_sequencer #(
    parameter logic [7:0] STACK_LIMIT = 8'hC0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic       cmd_op,
    input  logic [1:0] cmd_reg,
    output logic       cmd_ready,
    output logic [1:0] rf_ra,
    input  logic [7:0] rf_rd,
    output logic       rf_we,
    output logic [1:0] rf_wa,
    output logic [7:0] rf_wdata,
    output logic [7:0] mem_addr,
    output logic       mem_we,
    output logic [7:0] mem_wdata,
    output logic       mem_re,
    input  logic [7:0] mem_rdata,
    output logic       done,
    output logic       fault
);

    typedef enum logic [3:0] {
        IDLE,
        RD_SP,
        RD_SRC,
        MEM_WR,
        MEM_RD,
        MEM_WAIT,
        WB_DATA,
        WB_SP,
        FAULT
    } state_t;

    state_t     state_reg;
    logic [7:0] sp_reg;
    logic [7:0] data_reg;
    logic       op_reg;
    logic [1:0] sel_reg;
    logic       fault_next;

    // Fault is decided on the SP value as it is read, so no wrapped address is ever used.
    assign fault_next = op_reg ? (rf_rd == 8'hFF) : (rf_rd < STACK_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            sp_reg    <= 8'd0;
            data_reg  <= 8'd0;
            op_reg    <= 1'b0;
            sel_reg   <= 2'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cmd_valid) begin
                        op_reg    <= cmd_op;
                        sel_reg   <= cmd_reg;
                        state_reg <= RD_SP;
                    end
                end
                RD_SP: begin
                    sp_reg <= rf_rd;
                    if (fault_next)
                        state_reg <= FAULT;
                    else if (op_reg)
                        state_reg <= MEM_RD;
                    else
                        state_reg <= RD_SRC;
                end
                RD_SRC: begin
                    data_reg  <= rf_rd;
                    state_reg <= MEM_WR;
                end
                MEM_WR:   state_reg <= WB_SP;
                MEM_RD:   state_reg <= MEM_WAIT;
                MEM_WAIT: begin
                    data_reg  <= mem_rdata;
                    state_reg <= WB_DATA;
                end
                // Popping into R3 lets the popped value stand in for the SP update.
                WB_DATA:  state_reg <= (sel_reg == 2'd3) ? IDLE : WB_SP;
                WB_SP:    state_reg <= IDLE;
                FAULT:    state_reg <= IDLE;
                default:  state_reg <= IDLE;
            endcase
        end
    end

    always_comb begin
        cmd_ready = 1'b0;
        rf_ra     = 2'd0;
        rf_we     = 1'b0;
        rf_wa     = 2'd0;
        rf_wdata  = 8'd0;
        mem_addr  = 8'd0;
        mem_we    = 1'b0;
        mem_wdata = 8'd0;
        mem_re    = 1'b0;
        done      = 1'b0;
        fault     = 1'b0;
        case (state_reg)
            IDLE:   cmd_ready = 1'b1;
            RD_SP:  rf_ra = 2'd3;
            RD_SRC: rf_ra = sel_reg;
            MEM_WR: begin
                mem_we    = 1'b1;
                mem_addr  = sp_reg;
                mem_wdata = data_reg;
            end
            MEM_RD: begin
                mem_re   = 1'b1;
                mem_addr = sp_reg + 8'd1;
            end
            WB_DATA: begin
                rf_we    = 1'b1;
                rf_wa    = sel_reg;
                rf_wdata = data_reg;
                done     = (sel_reg == 2'd3);
            end
            WB_SP: begin
                rf_we    = 1'b1;
                rf_wa    = 2'd3;
                rf_wdata = op_reg ? (sp_reg + 8'd1) : (sp_reg - 8'd1);
                done     = 1'b1;
            end
            FAULT: begin
                done  = 1'b1;
                fault = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_stack_sequencer.sv
// Bench for stack_sequencer: register file and memory modelled around the DUT,
// directed vector table, hand-written corner sequences and a randomized run against a stack model.
module tb_stack_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_op;
    logic [1:0] cmd_reg;
    logic       cmd_ready;
    logic [1:0] rf_ra;
    logic [7:0] rf_rd;
    logic       rf_we;
    logic [1:0] rf_wa;
    logic [7:0] rf_wdata;
    logic [7:0] mem_addr;
    logic       mem_we;
    logic [7:0] mem_wdata;
    logic       mem_re;
    logic [7:0] mem_rdata;
    logic       done;
    logic       fault;

    always #5 clk = ~clk;

    stack_sequencer dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_reg(cmd_reg), .cmd_ready(cmd_ready),
        .rf_ra(rf_ra), .rf_rd(rf_rd), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wdata(rf_wdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .done(done), .fault(fault)
    );

    // Environment: register file (combinational read) and memory (one-cycle read latency)
    logic [7:0] rf [4];
    logic [7:0] mem [256];
    logic       bd_rf_we = 1'b0, bd_mem_we = 1'b0;
    logic [1:0] bd_rf_a = 2'd0;
    logic [7:0] bd_rf_d = 8'd0, bd_mem_a = 8'd0, bd_mem_d = 8'd0;

    assign rf_rd = rf[rf_ra];

    always @(posedge clk) begin
        if (bd_rf_we) rf[bd_rf_a] <= bd_rf_d;
        else if (rf_we) rf[rf_wa] <= rf_wdata;
        if (bd_mem_we) mem[bd_mem_a] <= bd_mem_d;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    typedef struct packed {
        logic       rf_we;
        logic [1:0] rf_wa;
        logic [7:0] rf_wdata;
        logic       mem_we;
        logic       mem_re;
        logic [7:0] mem_addr;
        logic [7:0] mem_wdata;
        logic       done;
        logic       fault;
    } obs_t;

    obs_t tr [16];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   r_lat;
    bit   r_flt;
    bit   r_any_strobe;

    // Reference model state
    logic [7:0] m_rf [4];
    logic [7:0] m_mem [256];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bd_rf(input logic [1:0] a, input logic [7:0] d);
        bd_rf_we = 1'b1; bd_rf_a = a; bd_rf_d = d;
        @(negedge clk);
        bd_rf_we = 1'b0;
    endtask

    task automatic bd_mem(input logic [7:0] a, input logic [7:0] d);
        bd_mem_we = 1'b1; bd_mem_a = a; bd_mem_d = d;
        @(negedge clk);
        bd_mem_we = 1'b0;
    endtask

    // Issue one command from a negedge; returns at the negedge of the IDLE cycle after done.
    task automatic run_cmd(input bit op, input logic [1:0] r);
        int viol = 0;
        bit got  = 0;
        for (int i = 0; i < 16; i++) tr[i] = '0;
        r_lat = 0; r_flt = 0; r_any_strobe = 0;
        chk("ready_at_issue", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_reg = r;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int c = 1; c < 14 && !got; c++) begin
            tr[c] = '{rf_we, rf_wa, rf_wdata, mem_we, mem_re, mem_addr, mem_wdata, done, fault};
            if ((32'(rf_we) + 32'(mem_we) + 32'(mem_re)) > 1) viol++;
            if (cmd_ready) viol++;
            if (rf_we || mem_we || mem_re) r_any_strobe = 1;
            if (done) begin
                got = 1; r_lat = c; r_flt = fault;
            end
            @(negedge clk);
        end
        chk("done_seen", {31'd0, got}, 32'd1);
        chk("busy_violations", viol, 0);
    endtask

    task automatic model_cmd(input bit op, input logic [1:0] r, output int lat, output bit flt);
        logic [7:0] sp = m_rf[3];
        flt = 0;
        if (!op) begin
            if (sp < 8'hC0) begin flt = 1; lat = 2; end
            else begin
                m_mem[sp] = m_rf[r];
                m_rf[3]   = sp - 8'd1;
                lat       = 4;
            end
        end else begin
            if (sp == 8'hFF) begin flt = 1; lat = 2; end
            else begin
                m_rf[r] = m_mem[sp + 8'd1];
                if (r != 2'd3) begin m_rf[3] = sp + 8'd1; lat = 5; end
                else lat = 4;
            end
        end
    endtask

    typedef struct {
        bit       op;
        bit [1:0] r;
        bit [7:0] sp_pre;
        int       lat;
        bit       flt;
        bit [7:0] sp_post;
    } vec_t;

    vec_t tbl [9];

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   e_lat;
        bit   e_flt;
        int   miss;
        int   quiet;
        logic [7:0] sp_choices [6];

        tbl = '{
            '{0, 2'd1, 8'hFF, 4, 0, 8'hFE},
            '{0, 2'd0, 8'hC0, 4, 0, 8'hBF},
            '{0, 2'd2, 8'hBF, 2, 1, 8'hBF},
            '{0, 2'd0, 8'h00, 2, 1, 8'h00},
            '{1, 2'd2, 8'hFF, 2, 1, 8'hFF},
            '{1, 2'd1, 8'hFE, 5, 0, 8'hFF},
            '{1, 2'd0, 8'hC0, 5, 0, 8'hC1},
            '{1, 2'd0, 8'hBF, 5, 0, 8'hC0},
            '{0, 2'd3, 8'hC1, 4, 0, 8'hC0}
        };
        sp_choices = '{8'hFF, 8'hFE, 8'hC0, 8'hC1, 8'hC3, 8'hE0};

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_reg = 2'd0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_ready", {31'd0, cmd_ready}, 32'd1);
        chk("reset_outputs", {28'd0, rf_we, mem_we, mem_re, done | fault}, 32'd0);
        rst = 1'b0;

        bd_rf(2'd0, 8'h11); bd_rf(2'd1, 8'h5A); bd_rf(2'd2, 8'h22); bd_rf(2'd3, 8'hFF);

        // PUSH R1 with empty stack
        run_cmd(0, 2'd1);
        chk("push_lat", r_lat, 4);
        chk("push_c3_memwr", {15'd0, tr[3].mem_we, tr[3].mem_addr, tr[3].mem_wdata}, {15'd0, 1'b1, 8'hFF, 8'h5A});
        chk("push_c4_wbsp", {19'd0, tr[4].rf_we, tr[4].rf_wa, tr[4].rf_wdata, tr[4].done, tr[4].fault},
            {19'd0, 1'b1, 2'd3, 8'hFE, 1'b1, 1'b0});
        chk("push_sp", rf[3], 8'hFE);

        // POP into R2
        run_cmd(1, 2'd2);
        chk("pop_lat", r_lat, 5);
        chk("pop_c2_memrd", {23'd0, tr[2].mem_re, tr[2].mem_addr}, {23'd0, 1'b1, 8'hFF});
        chk("pop_c4_wbdata", {20'd0, tr[4].rf_we, tr[4].rf_wa, tr[4].rf_wdata, tr[4].done},
            {20'd0, 1'b1, 2'd2, 8'h5A, 1'b0});
        chk("pop_c5_wbsp", {20'd0, tr[5].rf_we, tr[5].rf_wa, tr[5].rf_wdata, tr[5].done},
            {20'd0, 1'b1, 2'd3, 8'hFF, 1'b1});
        chk("pop_r2", rf[2], 8'h5A);

        // Underflow
        run_cmd(1, 2'd0);
        chk("uflow_c2", {30'd0, tr[2].done, tr[2].fault}, {30'd0, 2'b11});
        chk("uflow_lat", r_lat, 2);
        chk("uflow_strobes", {31'd0, r_any_strobe}, 32'd0);
        chk("uflow_sp", rf[3], 8'hFF);

        // Stack limit boundary, then overflow
        bd_rf(2'd3, 8'hC0);
        run_cmd(0, 2'd0);
        chk("limit_push_flt", {31'd0, r_flt}, 32'd0);
        chk("limit_push_sp", rf[3], 8'hBF);
        run_cmd(0, 2'd0);
        chk("oflow_flt", {31'd0, r_flt}, 32'd1);
        chk("oflow_lat", r_lat, 2);
        chk("oflow_strobes", {31'd0, r_any_strobe}, 32'd0);
        chk("oflow_sp", rf[3], 8'hBF);

        // PUSH R3 stores pre-decrement SP; POP into R3 skips SP writeback
        bd_rf(2'd3, 8'hFF);
        run_cmd(0, 2'd3);
        chk("push_r3_mem", mem[8'hFF], 8'hFF);
        chk("push_r3_sp", rf[3], 8'hFE);
        bd_mem(8'hFF, 8'h33);
        run_cmd(1, 2'd3);
        chk("pop_r3_lat", r_lat, 4);
        chk("pop_r3_c4", {19'd0, tr[4].rf_we, tr[4].rf_wa, tr[4].rf_wdata, tr[4].done, tr[4].fault},
            {19'd0, 1'b1, 2'd3, 8'h33, 1'b1, 1'b0});
        chk("pop_r3_val", rf[3], 8'h33);

        // Reset during MEM_WR aborts the PUSH
        bd_rf(2'd3, 8'hFF); bd_rf(2'd1, 8'h77);
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_reg = 2'd1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_in_memwr", {31'd0, mem_we}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready", {31'd0, cmd_ready}, 32'd1);
        quiet = 0;
        for (int c = 0; c < 4; c++) begin
            if (rf_we || mem_we || mem_re || done || fault) quiet++;
            @(negedge clk);
        end
        chk("abort_quiet", quiet, 0);
        chk("abort_sp", rf[3], 8'hFF);
        chk("abort_mem_kept", mem[8'hFF], 8'h77);
        run_cmd(0, 2'd1);
        chk("after_abort_lat", r_lat, 4);
        chk("after_abort_sp", rf[3], 8'hFE);

        // Vector table
        for (int i = 0; i < 9; i++) begin
            bd_rf(2'd3, tbl[i].sp_pre);
            run_cmd(tbl[i].op, tbl[i].r);
            chk($sformatf("vec%0d_lat", i), r_lat, tbl[i].lat);
            chk($sformatf("vec%0d_fault", i), {31'd0, r_flt}, {31'd0, tbl[i].flt});
            chk($sformatf("vec%0d_sp", i), rf[3], tbl[i].sp_post);
            $display("[TB] vec%0d op=%0d r=%0d sp %h -> %h lat=%0d fault=%0d",
                     i, tbl[i].op, tbl[i].r, tbl[i].sp_pre, rf[3], r_lat, r_flt);
        end

        // Randomized commands against the stack model
        for (int a = 0; a < 256; a++) begin
            m_mem[a] = 8'(a * 7 + 3);
            bd_mem(8'(a), m_mem[a]);
        end
        for (int i = 0; i < 3; i++) begin
            m_rf[i] = 8'($urandom_range(0, 255));
            bd_rf(2'(i), m_rf[i]);
        end
        m_rf[3] = 8'hF8;
        bd_rf(2'd3, 8'hF8);
        for (int n = 0; n < 300; n++) begin
            bit         op;
            logic [1:0] r;
            if (n % 40 == 39) begin
                m_rf[3] = sp_choices[$urandom_range(0, 5)];
                bd_rf(2'd3, m_rf[3]);
            end
            op = 1'($urandom_range(0, 1));
            r  = 2'($urandom_range(0, 3));
            if (op && r == 2'd3 && $urandom_range(0, 3) != 0) r = 2'd0;
            model_cmd(op, r, e_lat, e_flt);
            run_cmd(op, r);
            chk("rand_lat", r_lat, e_lat);
            chk("rand_fault", {31'd0, r_flt}, {31'd0, e_flt});
            chk("rand_rf", {rf[3], rf[2], rf[1], rf[0]}, {m_rf[3], m_rf[2], m_rf[1], m_rf[0]});
            $display("[TB] rand%0d op=%0d r=%0d lat=%0d fault=%0d sp=%h", n, op, r, r_lat, r_flt, rf[3]);
        end
        miss = 0;
        for (int a = 0; a < 256; a++)
            if (mem[a] !== m_mem[a]) miss++;
        chk("rand_mem_final", miss, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
